pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//   Program counter plus conditional-jump resolution; directly downstream of the
//   2-bit flags register, consuming its registered Z/LT outputs.
//   Each clock, either increments the PC, loads it from the bus (unconditional, or
//   conditional on flags), or holds it. Also provides a HALT state that freezes the PC.
//   Drives the address side of instruction fetch.
// PARAMETERS
//   WIDTH     16       PC and bus width in bits
//   RESET_PC  16'h0000 PC value after reset
// PORTS
//   clk        in   1      single system clock; all state updates on posedge
//   reset      in   1      synchronous, active-high reset
//   flags      in   2      flags register output: [1]=Z (result zero), [0]=LT (result negative)
//   jz         in   1      condition select: jump if Z
//   jlt        in   1      condition select: jump if LT
//   jgt        in   1      condition select: jump if !Z && !LT
//   pc_load    in   1      request to load PC from bus_in (subject to condition)
//   pc_inc     in   1      request to increment PC
//   bus_in     in   WIDTH  jump target
//   halt_req   in   1      enter HALT at next posedge
//   resume     in   1      leave HALT at next posedge
//   pc_out     out  WIDTH  current PC (registered)
//   taken      out  1      registered: 1 if previous cycle performed a bus load
//   halted     out  1      registered: 1 while in HALT
// BEHAVIOUR
//   Reset (sync, reset=1 at posedge): pc_out=RESET_PC, taken=0, halted=0, state=RUN.
//     Reset overrides every other input in the same cycle.
//   Condition (combinational, from flags sampled this cycle):
//     cond_sel = {jz,jlt,jgt}; cond_ok = (cond_sel==0) | (jz&Z) | (jlt&LT) | (jgt&!Z&!LT).
//     cond_sel==0 with pc_load=1 is an unconditional jump.
//     Z=1 and LT=1 together is legal; only jz/jlt can fire; jgt is false.
//   States: RUN, HALT (1 bit).
//     RUN:  halt_req=1 -> HALT; this cycle's PC update still happens.
//     HALT: resume=1 -> RUN; PC holds and taken=0 for every HALT cycle, including the exit cycle.
//           halt_req and resume both 1 in HALT -> RUN (resume wins).
//   PC update in RUN (priority order):
//     1. pc_load & cond_ok -> pc <= bus_in, taken <= 1
//     2. pc_inc            -> pc <= pc+1 (mod 2^WIDTH, FFFF->0000), taken <= 0
//     3. otherwise         -> hold, taken <= 0
//   pc_load=1 with cond_ok=0 falls through to rule 2/3, so a failed branch with
//     pc_inc=1 still advances the PC.
//   Latency: pc_out reflects a decision one posedge after inputs are sampled; no bypass.
//   Flags are consumed as-is (already registered upstream); no internal flag copy.
//   halted = (state==HALT), registered.
// STRUCTURE
//   Shared package: state encoding (RUN=0, HALT=1); flag bit indices
//     (FLAG_Z=1, FLAG_LT=0); RESET_PC default.
//   One sub-module: branch_cond (combinational; flags, jz, jlt, jgt -> cond_ok),
//     reused by the microcode decoder for skip logic.
//   Top: PC register, incrementer, mux, HALT FSM.
// TESTING
//   1 reset: reset=1 one posedge with pc_load=1, bus_in=1234 -> pc_out=0000, taken=0, halted=0.
//   2 increment/wrap: bus_in=FFFE, pc_load=1, then pc_inc x3 -> FFFE, FFFF, 0000, 0001.
//   3 conditional: flags=2'b10, jz=1, pc_load=1, bus_in=0100 -> pc=0100, taken=1;
//     then flags=2'b00, jz=1, pc_load=1, pc_inc=1 -> pc=0101, taken=0.
//   4 jgt: flags=00 -> loads bus_in=0200; flags=01 -> no load; flags=11 with jlt=1 -> loads.
//   5 halt: halt_req with pc_inc -> pc increments once, then holds for 4 cycles with pc_inc=1
//     and taken=0; resume -> halted=0; pc_inc -> pc advances the next cycle.
//   6 mid-halt reset: in HALT, reset=1 -> pc=0000, halted=0, RUN.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the program counter / branch unit and its condition logic.
package pc_branch_unit_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    localparam int FLAG_Z  = 1;
    localparam int FLAG_LT = 0;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_branch_unit_branch_cond.sv
// Branch condition evaluation from registered Z/LT flags; also used for microcode skips.
module branch_cond
    import pc_branch_unit_pkg::*;
(
    input  logic [1:0] flags,
    input  logic       jz,
    input  logic       jlt,
    input  logic       jgt,
    output logic       cond_ok
);

    logic z, lt;

    assign z  = flags[FLAG_Z];
    assign lt = flags[FLAG_LT];

    // No condition selected means an unconditional jump.
    assign cond_ok = ~(jz | jlt | jgt)
                   | (jz & z)
                   | (jlt & lt)
                   | (jgt & ~z & ~lt);

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with conditional bus load, increment, and a RUN/HALT freeze state.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       flags,
    input  logic             jz,
    input  logic             jlt,
    input  logic             jgt,
    input  logic             pc_load,
    input  logic             pc_inc,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc_out,
    output logic             taken,
    output logic             halted
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             cond_ok;

    branch_cond u_cond (
        .flags   (flags),
        .jz      (jz),
        .jlt     (jlt),
        .jgt     (jgt),
        .cond_ok (cond_ok)
    );

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                // A failed branch falls through to the increment path.
                if (pc_load && cond_ok) begin
                    pc_d    = bus_in;
                    taken_d = 1'b1;
                end else if (pc_inc) begin
                    pc_d = pc_q + WIDTH'(1);
                end
                if (halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    assign pc_out = pc_q;
    assign taken  = taken_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized checks of pc_branch_unit against a behavioural model.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset, jz, jlt, jgt, pc_load, pc_inc, halt_req, resume;
    logic [1:0]  flags;
    logic [15:0] bus_in, pc_out;
    logic        taken, halted;

    int checks = 0;
    int passes = 0;

    int m_pc     = 0;
    bit m_taken  = 0;
    bit m_halted = 0;

    pc_branch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .flags(flags), .jz(jz), .jlt(jlt), .jgt(jgt),
        .pc_load(pc_load), .pc_inc(pc_inc), .bus_in(bus_in),
        .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .taken(taken), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input bit rst, input bit ld, input bit inc, input logic [15:0] bus,
                         input logic [1:0] fl, input bit z, input bit l, input bit g,
                         input bit hr, input bit rs);
        reset = rst; pc_load = ld; pc_inc = inc; bus_in = bus; flags = fl;
        jz = z; jlt = l; jgt = g; halt_req = hr; resume = rs;
    endtask

    // Model: advance expected state from the inputs currently applied, then clock and compare.
    task automatic step(input string tag);
        bit zf, lf, cond;
        zf = flags[1];
        lf = flags[0];
        if (reset) begin
            m_pc = 0; m_taken = 0; m_halted = 0;
        end else if (m_halted) begin
            m_taken = 0;
            if (resume) m_halted = 0;
        end else begin
            cond = (!jz && !jlt && !jgt) || (jz && zf) || (jlt && lf) || (jgt && !zf && !lf);
            if (pc_load && cond) begin
                m_pc = int'(bus_in); m_taken = 1;
            end else begin
                if (pc_inc) m_pc = (m_pc + 1) % 65536;
                m_taken = 0;
            end
            if (halt_req) m_halted = 1;
        end
        @(posedge clk);
        #1;
        check({tag, ".pc"}, pc_out, 16'(m_pc));
        check({tag, ".taken"}, {15'b0, taken}, {15'b0, m_taken});
        check({tag, ".halted"}, {15'b0, halted}, {15'b0, m_halted});
    endtask

    initial begin
        drive(1, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);

        // 1: reset overrides a pending load
        drive(1, 1, 0, 16'h1234, 2'b00, 0, 0, 0, 0, 0);
        step("reset");
        check("reset.const", pc_out, 16'h0000);

        // 2: load then increment across the wrap
        drive(0, 1, 0, 16'hFFFE, 2'b00, 0, 0, 0, 0, 0);
        step("wrap.load");
        check("wrap.fffe", pc_out, 16'hFFFE);
        drive(0, 0, 1, 16'h0, 2'b00, 0, 0, 0, 0, 0);
        step("wrap.i1");
        step("wrap.i2");
        check("wrap.0000", pc_out, 16'h0000);
        step("wrap.i3");
        check("wrap.0001", pc_out, 16'h0001);

        // 3: conditional jz taken, then not taken with increment fallthrough
        drive(0, 1, 0, 16'h0100, 2'b10, 1, 0, 0, 0, 0);
        step("jz.taken");
        check("jz.0100", pc_out, 16'h0100);
        drive(0, 1, 1, 16'h0777, 2'b00, 1, 0, 0, 0, 0);
        step("jz.fall");
        check("jz.0101", pc_out, 16'h0101);

        // 4: jgt and the Z&LT corner
        drive(0, 1, 0, 16'h0200, 2'b00, 0, 0, 1, 0, 0);
        step("jgt.00");
        drive(0, 1, 0, 16'h0300, 2'b01, 0, 0, 1, 0, 0);
        step("jgt.01");
        check("jgt.hold", pc_out, 16'h0200);
        drive(0, 1, 0, 16'h0400, 2'b11, 0, 0, 1, 0, 0);
        step("jgt.11");
        drive(0, 1, 0, 16'h0500, 2'b11, 0, 1, 0, 0, 0);
        step("jlt.11");
        check("jlt.0500", pc_out, 16'h0500);

        // 5: halt with a final increment, frozen while halted, resume
        drive(0, 0, 1, 16'h0, 2'b00, 0, 0, 0, 1, 0);
        step("halt.enter");
        check("halt.0501", pc_out, 16'h0501);
        drive(0, 1, 1, 16'h0999, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("halt.hold");
        check("halt.frozen", pc_out, 16'h0501);
        drive(0, 0, 1, 16'h0, 2'b00, 0, 0, 0, 1, 1);
        step("halt.resume");
        drive(0, 0, 1, 16'h0, 2'b00, 0, 0, 0, 0, 0);
        step("halt.run");
        check("halt.0502", pc_out, 16'h0502);

        // 6: reset while halted
        drive(0, 0, 0, 16'h0, 2'b00, 0, 0, 0, 1, 0);
        step("mh.enter");
        drive(1, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0, 0);
        step("mh.reset");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  16'($urandom), 2'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
